// File: rtl/delta_interp_if.sv
// delta_interp_if
//   Groups the segment-request, status and output-stream signals of
//   delta_interp.
//   Ports (signals):
//     start, y_base, delta : segment request (driver -> interpolator)
//     busy, sat, done      : segment status   (interpolator -> driver)
//     out_valid/out_ready  : sample stream handshake
//     out_data, out_index,
//     out_last             : sample payload
//   Modports:
//     slave  : the interpolator side (serves segment requests)
//     master : the requesting side (issues requests, consumes samples)
interface delta_interp_if #(
  parameter int X_DISPLACEMENT = 16,
  parameter int DSIZE          = 16,
  parameter int DT_I           = 8,
  parameter int DT_D           = 4
);
  localparam int IW = $clog2(X_DISPLACEMENT);

  logic                   start;
  logic [DSIZE-1:0]       y_base;
  logic [DT_I+DT_D-1:0]   delta;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [DSIZE-1:0]       out_data;
  logic [IW-1:0]          out_index;
  logic                   out_last;
  logic                   sat;
  logic                   done;

  modport slave (
    input  start, y_base, delta, out_ready,
    output busy, out_valid, out_data, out_index, out_last, sat, done
  );

  modport master (
    output start, y_base, delta, out_ready,
    input  busy, out_valid, out_data, out_index, out_last, sat, done
  );
endinterface

// File: rtl/delta_interp.sv
// delta_interp
//   Walks one line segment of X_DISPLACEMENT steps. Starting from y_base it
//   adds the fixed-point slope (DT_I.DT_D) once per accepted sample and
//   emits a rounded (half up), saturated DSIZE-bit Y value per step on a
//   valid/ready stream.
//   Ports:
//     clock : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : delta_interp_if.slave (start/y_base/delta request, busy/sat/
//             done status, out_valid/out_ready/out_data/out_index/out_last)
module delta_interp #(
  parameter int X_DISPLACEMENT = 16,
  parameter int DSIZE          = 16,
  parameter int DT_I           = 8,
  parameter int DT_D           = 4
) (
  input  logic          clock,
  input  logic          rst_n,
  delta_interp_if.slave bus
);

  localparam int IW = $clog2(X_DISPLACEMENT);
  localparam int AW = DSIZE + DT_D;
  localparam int DW = DT_I + DT_D;
  localparam logic [IW-1:0] LAST_IDX = IW'(X_DISPLACEMENT - 1);
  localparam logic [AW:0]   HALF     = {{AW{1'b0}}, 1'b1} << (DT_D - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   step_q, step_d;
  logic [IW-1:0]   index_q, index_d;
  logic            sat_q, sat_d;

  logic            handshake;
  logic            lastIdx;
  logic [AW:0]     sum;
  logic            addOvf;
  logic [DSIZE:0]  rndHi;
  logic [DT_D-1:0] rndLo;
  logic            roundOvf;
  logic            unusedRndLo;

  assign handshake = (state_q == RUN) && bus.out_ready;
  assign lastIdx   = (index_q == LAST_IDX);

  // One extra bit catches the carry-out of the step add.
  assign sum    = {1'b0, acc_q} + (AW+1)'(step_q);
  assign addOvf = sum[AW];

  // Round half up; the top bit of rndHi flags a result beyond DSIZE bits.
  assign {rndHi, rndLo} = {1'b0, acc_q} + HALF;
  assign roundOvf       = rndHi[DSIZE];
  // Fractional bits drop out once the sample has been rounded.
  assign unusedRndLo    = ^rndLo;

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (handshake && lastIdx) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      step_q  <= '0;
      index_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      step_q  <= step_d;
      index_q <= index_d;
      sat_q   <= sat_d;
    end
  end

  // A clamped accumulator stays all-ones because any further add carries out
  always_comb begin
    acc_d   = acc_q;
    step_d  = step_q;
    index_d = index_q;
    sat_d   = sat_q;
    if (state_q == IDLE && bus.start) begin
      acc_d   = {bus.y_base, {DT_D{1'b0}}};
      step_d  = bus.delta;
      index_d = '0;
      sat_d   = 1'b0;
    end else if (handshake) begin
      sat_d = sat_q | roundOvf;
      if (!lastIdx) begin
        index_d = index_q + 1'b1;
        acc_d   = addOvf ? {AW{1'b1}} : sum[AW-1:0];
        sat_d   = sat_q | roundOvf | addOvf;
      end
    end
  end

  // Outputs; sat also reflects a clamp of the sample currently on offer
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.out_valid = (state_q == RUN);
    bus.out_data  = '0;
    bus.out_index = '0;
    bus.out_last  = 1'b0;
    bus.done      = (state_q == DONE);
    bus.sat       = sat_q;
    if (state_q == RUN) begin
      bus.out_data  = roundOvf ? {DSIZE{1'b1}} : rndHi[DSIZE-1:0];
      bus.out_index = index_q;
      bus.out_last  = lastIdx;
      bus.sat       = sat_q | roundOvf;
    end
  end

endmodule

// File: tb/tb_delta_interp.sv
// tb_delta_interp
//   Directed bench for delta_interp. Expected samples are computed from the
//   segment parameters and queued when a start is driven; they are popped
//   and compared as the DUT hands samples over.
module tb_delta_interp;

  localparam int X_DISPLACEMENT = 16;
  localparam int DSIZE          = 16;
  localparam int DT_I           = 8;
  localparam int DT_D           = 4;
  localparam int IW             = $clog2(X_DISPLACEMENT);
  localparam int DW             = DT_I + DT_D;
  localparam longint MAXACC     = (longint'(1) << (DSIZE + DT_D)) - 1;
  localparam longint MAXY       = (longint'(1) << DSIZE) - 1;
  localparam longint HALF       = longint'(1) << (DT_D - 1);

  typedef struct {
    logic [DSIZE-1:0] data;
    logic [IW-1:0]    idx;
    logic             last;
    logic             sat;
  } sample_t;

  logic    clock = 1'b0;
  logic    rst_n = 1'b1;
  sample_t expQ[$];
  logic    expSat = 1'b0;
  int      errors = 0;
  int      checks = 0;

  always #5 clock = ~clock;

  delta_interp_if #(
    .X_DISPLACEMENT(X_DISPLACEMENT), .DSIZE(DSIZE), .DT_I(DT_I), .DT_D(DT_D)
  ) bus ();

  delta_interp #(
    .X_DISPLACEMENT(X_DISPLACEMENT), .DSIZE(DSIZE), .DT_I(DT_I), .DT_D(DT_D)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start at a negedge and queue the whole expected segment
  task automatic applyStimulus(input logic [DSIZE-1:0] y, input logic [DW-1:0] d);
    longint acc;
    longint r;
    logic   s;
    bus.start  = 1'b1;
    bus.y_base = y;
    bus.delta  = d;
    expQ.delete();
    s = 1'b0;
    for (int k = 0; k < X_DISPLACEMENT; k++) begin
      acc = longint'(y) * (longint'(1) << DT_D) + longint'(k) * longint'(d);
      if (acc > MAXACC) begin
        acc = MAXACC;
        s   = 1'b1;
      end
      r = (acc + HALF) >> DT_D;
      if (r > MAXY) begin
        r = MAXY;
        s = 1'b1;
      end
      expQ.push_back('{data: DSIZE'(r), idx: IW'(k),
                       last: (k == X_DISPLACEMENT - 1), sat: s});
    end
    expSat = s;
    @(negedge clock);
    bus.start  = 1'b0;
    bus.y_base = DSIZE'($urandom);
    bus.delta  = DW'($urandom);
  endtask

  // Consume one segment: optional stall at stallK, optional ignored start
  // pulses at sample pokeK and in the done cycle
  task automatic drainSegment(input int stallK, input int stallN,
                              input int pokeK, input bit pokeDone);
    sample_t s;
    int      stalls;
    int      cyc;
    bit      finished;
    bit      ready;
    stalls   = 0;
    finished = 1'b0;
    for (cyc = 0; cyc < 200 && !finished; cyc++) begin
      bus.start = 1'b0;
      if (bus.out_valid) begin
        if (pokeK == int'(bus.out_index)) begin
          bus.start  = 1'b1;
          bus.y_base = DSIZE'($urandom);
          bus.delta  = DW'($urandom);
        end
        ready = !(int'(bus.out_index) == stallK && stalls < stallN);
        bus.out_ready = ready;
        if (expQ.size() == 0) begin
          checkOutput("extra_sample", 32'(bus.out_valid), 32'(0));
        end else if (!ready) begin
          stalls++;
          checkOutput("stall_data", 32'(bus.out_data), 32'(expQ[0].data));
          checkOutput("stall_index", 32'(bus.out_index), 32'(expQ[0].idx));
        end else begin
          s = expQ.pop_front();
          checkOutput("sample_data", 32'(bus.out_data), 32'(s.data));
          checkOutput("sample_index", 32'(bus.out_index), 32'(s.idx));
          checkOutput("sample_last", 32'(bus.out_last), 32'(s.last));
          checkOutput("sample_sat", 32'(bus.sat), 32'(s.sat));
          checkOutput("sample_busy", 32'(bus.busy), 32'(1));
        end
      end else if (bus.done) begin
        checkOutput("done_busy", 32'(bus.busy), 32'(1));
        checkOutput("done_left", 32'(expQ.size()), 32'(0));
        checkOutput("seg_cycles", 32'(cyc), 32'(X_DISPLACEMENT + stallN));
        checkOutput("done_sat", 32'(bus.sat), 32'(expSat));
        if (pokeDone) bus.start = 1'b1;
        finished = 1'b1;
      end
      @(negedge clock);
    end
    checkOutput("seg_finished", 32'(finished), 32'(1));
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("idle_busy", 32'(bus.busy), 32'(0));
    checkOutput("idle_done", 32'(bus.done), 32'(0));
    checkOutput("idle_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("idle_sat", 32'(bus.sat), 32'(expSat));
  endtask

  initial begin
    sample_t s;
    bus.start     = 1'b0;
    bus.y_base    = '0;
    bus.delta     = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_busy", 32'(bus.busy), 32'(0));
    checkOutput("rst_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("rst_done", 32'(bus.done), 32'(0));
    checkOutput("rst_sat", 32'(bus.sat), 32'(0));
    checkOutput("rst_data", 32'(bus.out_data), 32'(0));
    checkOutput("rst_last", 32'(bus.out_last), 32'(0));
    repeat (2) @(negedge clock);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;

    $display("[TB] flat segment");
    applyStimulus(16'd500, 12'h000);
    drainSegment(-1, 0, -1, 1'b0);

    $display("[TB] slope 1.5");
    applyStimulus(16'd100, 12'h018);
    drainSegment(-1, 0, -1, 1'b0);

    $display("[TB] backpressure at k=5");
    applyStimulus(16'd100, 12'h018);
    drainSegment(5, 3, -1, 1'b0);

    $display("[TB] saturation");
    applyStimulus(16'hFFF0, 12'hFFF);
    drainSegment(-1, 0, -1, 1'b0);
    @(negedge clock);
    checkOutput("sat_hold_idle", 32'(bus.sat), 32'(1));

    $display("[TB] ignored start pulses");
    applyStimulus(16'd7, 12'h010);
    drainSegment(-1, 0, 3, 1'b1);
    @(negedge clock);
    checkOutput("ignored_start_busy", 32'(bus.busy), 32'(0));

    $display("[TB] reset mid-segment");
    applyStimulus(16'd100, 12'h018);
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid && bus.out_index == IW'(7)) break;
      if (bus.out_valid && expQ.size() != 0) begin
        s = expQ.pop_front();
        checkOutput("pre_reset_data", 32'(bus.out_data), 32'(s.data));
      end
      @(negedge clock);
    end
    checkOutput("pre_reset_index", 32'(bus.out_index), 32'(7));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'(0));
    checkOutput("mid_rst_done", 32'(bus.done), 32'(0));
    expQ.delete();
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("post_rst_valid", 32'(bus.out_valid), 32'(0));
      checkOutput("post_rst_busy", 32'(bus.busy), 32'(0));
    end
    applyStimulus(16'd321, 12'h020);
    drainSegment(-1, 0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
